uart_resp_arb: RTL and testbench
================================

Name: uart_resp_arb

Overview:
- Shares the single UART transmit-response channel (send_resp / resp / resp_sent on the UART wrapper) between NREQ independent requesters, e.g. command ack, telemetry and error reporter.
- Round-robin arbitration, one byte per grant, an enforced inter-byte gap, and a watchdog on resp_sent.
- Sits between the UART wrapper and the command/telemetry logic.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clocks inserted after each resp_sent before the next grant (0 allowed).
- TO_CYCLES, 65535, clocks to wait for resp_sent before declaring a timeout (must be >0).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  level request per requester; held until its gnt.
- req_data  input  8*NREQ  byte per requester; slice i = req_data[8*i+7:8*i]; held stable while req[i] is high.
- gnt  output  NREQ  one-hot, one-cycle pulse: byte of requester i accepted.
- done  output  NREQ  one-hot, one-cycle pulse: requester i's byte finished (resp_sent seen).
- send_resp  output  1  one-cycle transmit strobe to the UART wrapper.
- resp  output  8  byte to transmit.
- resp_sent  input  1  transmit-complete pulse from the UART wrapper.
- busy  output  1  high in every state except IDLE.
- timeout  output  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE; gnt=0, done=0, send_resp=0, resp=8'h00, busy=0, timeout=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
- All outputs are registered.
- States: IDLE, SEND, WAIT, GAP.
- IDLE:
  - If |req, winner w = first i with req[i] set, scanning last+1, last+2, ... modulo NREQ.
  - On that edge: resp<=req_data slice w, owner<=w, gnt[w]<=1, send_resp<=1, go SEND.
  - Latency: req sampled in cycle N gives gnt and send_resp high in cycle N+1.
- SEND:
  - Lasts exactly one cycle; gnt and send_resp drop at its end.
  - Watchdog counter loaded with TO_CYCLES; go WAIT.
- WAIT:
  - resp held constant.
  - On resp_sent: done[owner]<=1 (one cycle), last<=owner. If GAP_CYCLES==0 go IDLE, else load gap counter with GAP_CYCLES-1 and go GAP.
  - Else if the watchdog reaches 0: timeout<=1 (one cycle), last<=owner, no done, go IDLE.
  - resp_sent and expiry in the same cycle: resp_sent wins, no timeout.
- GAP:
  - Counts down; at 0 go IDLE.
  - Total gap between done and the next gnt is GAP_CYCLES+1 clocks.
- resp_sent outside WAIT, including during SEND, is ignored.
- Requests arriving outside IDLE wait. A req dropped before its gnt is simply not served; no error.
- Each requester owns at most one in-flight byte, so gnt[i] is never reissued before done[i] or timeout.
- rst asserted in any state aborts the transaction: no done, no timeout; next cycle has all reset values.
- Counters are $clog2(max(TO_CYCLES, GAP_CYCLES)+1) bits; no wrap, they stop at 0.

Optional Feature:
- Macro: UART_RESP_ARB_FIXED_PRI_EN.
- Defined: arbitration is fixed priority (lowest index wins) and the last pointer is not implemented.
- Undefined: round-robin as described above.
- All other timing is identical in both builds.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum typedef arb_state_t {IDLE, SEND, WAIT, GAP}.
  - localparam default widths.
  - function rr_pick(req, last) returning the winner index.
- One sub-module: rr_arb_pick, the combinational round-robin/fixed-priority selector, parameterised by NREQ; the macro is resolved inside it.
- FSM, counters and output registers stay in uart_resp_arb.

Test Plan:
- After reset, req=4'b0001, slice0=8'hA5 -> next cycle gnt=4'b0001, send_resp=1, resp=8'hA5; resp_sent 10 cycles later -> done=4'b0001 one cycle, then gnt blocked for 17 cycles (GAP_CYCLES=16).
- req=4'b1111 held, prompt resp_sent each time -> gnt order 0,1,2,3,0; with UART_RESP_ARB_FIXED_PRI_EN defined -> 0,0,0 while req[0] is held.
- Never drive resp_sent, TO_CYCLES=20 -> timeout pulses 20 cycles after SEND, busy drops, no done; next req granted normally.
- resp_sent pulsed in IDLE and during SEND -> ignored; done is issued only for the resp_sent seen in WAIT.
- rst asserted during WAIT with req[2] pending -> all outputs 0 next cycle, no done[2]; after release, req[0] and req[2] both high -> req[0] wins.
- GAP_CYCLES=0, req[1] held -> regrant exactly 1 cycle after done[1].

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART response arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    GAP
  } arb_state_t;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned IDX_W    = 3;

  // Round-robin winner: first set request after 'last', wrapping modulo nreq.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                               input logic [IDX_W-1:0]    last,
                                               input int unsigned         nreq);
    logic [IDX_W-1:0] win;
    logic             found;
    int unsigned      j;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_NREQ; k++) begin
      if (k <= nreq) begin
        j = (32'(last) + k) % nreq;
        if (!found && req[j[IDX_W-1:0]]) begin
          win   = j[IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational requester selector for uart_resp_arb.
// Build option: UART_RESP_ARB_FIXED_PRI_EN selects fixed priority (lowest index).
module rr_arb_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] pick
);

  localparam int unsigned IW = $clog2(NREQ);

`ifdef UART_RESP_ARB_FIXED_PRI_EN
  logic unused_last;
  assign unused_last = ^last;

  // Lowest set index wins.
  always_comb begin
    logic found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[IW'(i)]) begin
        pick  = IW'(i);
        found = 1'b1;
      end
    end
  end
`else
  // Round-robin starting just after the previous owner.
  always_comb begin
    pick = IW'(rr_pick(MAX_NREQ'(req), IDX_W'(last), NREQ));
  end
`endif

endmodule

// File: rtl/uart_resp_arb.sv
// Arbitrates NREQ byte requesters onto one UART response channel:
// one byte per grant, watchdog on resp_sent, fixed idle gap between bytes.
// Build option: UART_RESP_ARB_FIXED_PRI_EN (fixed priority, no last pointer).
module uart_resp_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TO_CYCLES  = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic                send_resp,
  output logic [7:0]          resp,
  input  logic                resp_sent,
  output logic                busy,
  output logic                timeout
);

  localparam int unsigned IW      = $clog2(NREQ);
  localparam int unsigned CNT_MAX = (TO_CYCLES > GAP_CYCLES) ? TO_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TO_LOAD  = CW'(TO_CYCLES);
  localparam logic [CW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  arb_state_t     state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  last_q;
  logic [IW-1:0]  pick;
  logic [CW-1:0]  wd_q, wd_d;
  logic [CW-1:0]  gap_q, gap_d;
  logic [NREQ-1:0] gnt_d, done_d;
  logic [7:0]     resp_d;
  logic           send_d, busy_d, timeout_d, txn_end;

  rr_arb_pick #(.NREQ(NREQ)) u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick)
  );

`ifdef UART_RESP_ARB_FIXED_PRI_EN
  assign last_q = '0;
`else
  // Round-robin pointer follows the owner of each finished or abandoned byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IW'(NREQ - 1);
    end else if (txn_end) begin
      last_q <= owner_q;
    end
  end
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      wd_q      <= '0;
      gap_q     <= '0;
      gnt       <= '0;
      done      <= '0;
      send_resp <= 1'b0;
      resp      <= 8'h00;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
      gnt       <= gnt_d;
      done      <= done_d;
      send_resp <= send_d;
      resp      <= resp_d;
      busy      <= busy_d;
      timeout   <= timeout_d;
    end
  end

  // Next-state and next-output decode; the watchdog expires on the WAIT
  // cycle where it decrements to zero, so resp_sent in that cycle still wins.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
    gnt_d     = '0;
    done_d    = '0;
    send_d    = 1'b0;
    resp_d    = resp;
    timeout_d = 1'b0;
    txn_end   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          resp_d      = req_data[{pick, 3'b000} +: 8];
          owner_d     = pick;
          gnt_d[pick] = 1'b1;
          send_d      = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        wd_d    = TO_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (resp_sent) begin
          done_d[owner_q] = 1'b1;
          txn_end         = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end else begin
          if (wd_q != '0) wd_d = wd_q - ONE;
          if (wd_q <= ONE) begin
            timeout_d = 1'b1;
            txn_end   = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - ONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_uart_resp_arb.sv
// Self-checking bench for uart_resp_arb (NREQ=4, GAP_CYCLES=16, TO_CYCLES=20)
// plus a second instance with GAP_CYCLES=0 for back-to-back regrant.
module tb_uart_resp_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt, done;
  logic        send_resp, resp_sent, busy, timeout;
  logic [7:0]  resp;

  logic [3:0]  req_b;
  logic [31:0] req_data_b;
  logic [3:0]  gnt_b, done_b;
  logic        send_resp_b, resp_sent_b, busy_b, timeout_b;
  logic [7:0]  resp_b;

  int total = 0;
  int bad   = 0;
  int m_last = 3;

  typedef struct packed {
    int         idx;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  uart_resp_arb #(.NREQ(4), .GAP_CYCLES(16), .TO_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .done(done), .send_resp(send_resp), .resp(resp), .resp_sent(resp_sent),
    .busy(busy), .timeout(timeout)
  );

  uart_resp_arb #(.NREQ(4), .GAP_CYCLES(0), .TO_CYCLES(20)) dut0 (
    .clk(clk), .rst(rst), .req(req_b), .req_data(req_data_b), .gnt(gnt_b),
    .done(done_b), .send_resp(send_resp_b), .resp(resp_b), .resp_sent(resp_sent_b),
    .busy(busy_b), .timeout(timeout_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [3:0] r, input int last);
`ifdef UART_RESP_ARB_FIXED_PRI_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (last + k) % 4;
      if (r[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] r, output int w);
    exp_t e;
    w = model_pick(r, m_last);
    e.idx  = w;
    e.data = req_data[8*w +: 8];
    sb_q.push_back(e);
  endtask

  task automatic wait_gnt(output int n);
    logic got;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      n++;
      if (gnt != '0) got = 1'b1;
    end
    chk("gnt_seen", 32'(got), 1);
  endtask

  // Called in the grant cycle; resp_sent is driven 'dly' cycles later.
  task automatic serve(input int idx, input int dly, input logic [7:0] b);
    for (int i = 0; i < dly; i++) step();
    chk("resp_hold", 32'(resp), 32'(b));
    resp_sent = 1'b1;
    step();
    resp_sent = 1'b0;
    chk("done", 32'(done), 32'(1) << idx);
    chk("no_to", 32'(timeout), 0);
    m_last = idx;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_last = 3;
  endtask

  // Scoreboard: every grant must match the oldest expected (index, byte).
  always @(negedge clk) begin
    if (rst === 1'b0 && gnt != '0) begin
      if (sb_q.size() == 0) begin
        chk("gnt_unexp", 32'(gnt), 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("gnt_idx", 32'(gnt), 32'(1) << mon_e.idx);
        chk("gnt_resp", 32'(resp), 32'(mon_e.data));
        chk("gnt_send", 32'(send_resp), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n, w;
    rst = 1'b1; req = '0; req_data = '0; resp_sent = 1'b0;
    req_b = '0; req_data_b = '0; resp_sent_b = 1'b0;
    step();
    step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_send", 32'(send_resp), 0);
    chk("rst_resp", 32'(resp), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_to", 32'(timeout), 0);
    rst = 1'b0;
    step();

    // Single byte, resp_sent 10 cycles after grant, then 17-cycle gap.
    req = 4'b0001; req_data[7:0] = 8'hA5;
    push_exp(req, w);
    wait_gnt(n);
    chk("lat_first", 32'(n), 1);
    chk("busy_send", 32'(busy), 1);
    req = '0;
    step();
    chk("send_drop", 32'(send_resp), 0);
    serve(0, 9, 8'hA5);
    chk("busy_gap", 32'(busy), 1);
    req = 4'b0001;
    push_exp(req, w);
    wait_gnt(n);
    chk("gap_len", 32'(n), 17);
    req = '0;
    serve(0, 1, 8'hA5);

    // All requesters held: order follows the arbitration model.
    do_reset();
    req = 4'b1111; req_data = 32'h44_33_22_11;
    for (int k = 0; k < 5; k++) begin
      push_exp(req, w);
      wait_gnt(n);
      chk("rr_lat", 32'(n), (k == 0) ? 32'd1 : 32'd17);
      serve(w, 1, req_data[8*w +: 8]);
    end
    req = '0;

    // Watchdog: no resp_sent, timeout 21 cycles after the grant cycle.
    req = 4'b0100; req_data[23:16] = 8'h5C;
    push_exp(req, w);
    wait_gnt(n);
    req = '0;
    begin
      logic seen;
      seen = 1'b0;
      n = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        step();
        n++;
        if (done != '0) chk("to_no_done", 32'(done), 0);
        if (timeout) seen = 1'b1;
      end
      chk("to_seen", 32'(seen), 1);
    end
    chk("to_lat", 32'(n), 21);
    chk("to_busy", 32'(busy), 0);
    chk("to_done", 32'(done), 0);
    m_last = 2;
    step();
    chk("to_pulse", 32'(timeout), 0);
    // Next request granted at once; resp_sent on the last watchdog cycle wins.
    req = 4'b0001; req_data[7:0] = 8'h3E;
    push_exp(req, w);
    wait_gnt(n);
    chk("to_regrant", 32'(n), 1);
    req = '0;
    serve(0, 20, 8'h3E);

    // resp_sent in IDLE and in SEND is ignored.
    for (int i = 0; i < 17; i++) step();
    resp_sent = 1'b1;
    step();
    resp_sent = 1'b0;
    chk("idle_rs_done", 32'(done), 0);
    chk("idle_rs_busy", 32'(busy), 0);
    req = 4'b0010; req_data[15:8] = 8'h77;
    push_exp(req, w);
    wait_gnt(n);
    req = '0;
    resp_sent = 1'b1;
    step();
    resp_sent = 1'b0;
    chk("send_rs_done", 32'(done), 0);
    step();
    chk("send_rs_done2", 32'(done), 0);
    serve(1, 1, 8'h77);

    // Reset in WAIT with req[2] pending, then 0 beats 2 after reset.
    for (int i = 0; i < 17; i++) step();
    req = 4'b0001; req_data[7:0] = 8'hA5; req_data[23:16] = 8'hC2;
    push_exp(req, w);
    wait_gnt(n);
    req = 4'b0101;
    step();
    step();
    rst = 1'b1;
    step();
    chk("wrst_gnt", 32'(gnt), 0);
    chk("wrst_done", 32'(done), 0);
    chk("wrst_send", 32'(send_resp), 0);
    chk("wrst_resp", 32'(resp), 0);
    chk("wrst_busy", 32'(busy), 0);
    chk("wrst_to", 32'(timeout), 0);
    rst = 1'b0;
    m_last = 3;
    push_exp(req, w);
    wait_gnt(n);
    chk("wrst_lat", 32'(n), 1);
    req = 4'b0100;
    serve(0, 1, 8'hA5);
    push_exp(req, w);
    wait_gnt(n);
    chk("wrst_next", 32'(n), 17);
    req = '0;
    serve(2, 1, 8'hC2);

    // GAP_CYCLES=0 instance: regrant one cycle after done.
    req_b = 4'b0010; req_data_b[15:8] = 8'h3C;
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        step();
        if (gnt_b != '0) got = 1'b1;
      end
      chk("g0_gnt_seen", 32'(got), 1);
    end
    chk("g0_gnt", 32'(gnt_b), 32'h2);
    step();
    resp_sent_b = 1'b1;
    step();
    resp_sent_b = 1'b0;
    chk("g0_done", 32'(done_b), 32'h2);
    chk("g0_no_gnt", 32'(gnt_b), 0);
    step();
    chk("g0_regrant", 32'(gnt_b), 32'h2);
    chk("g0_resp", 32'(resp_b), 32'h3C);
    req_b = '0;

    step();
    step();
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
